// File: rtl/scroll_ticker_if.sv
// rtl/scroll_ticker_if.sv - message buffer write port for scroll_ticker
interface scroll_ticker_if #(
   parameter int MSG_LEN = 16,
   localparam int AW = $clog2(MSG_LEN)
);
   logic          we;
   logic [AW-1:0] addr;
   logic [4:0]    data;

   modport master (output we, addr, data);
   modport slave  (input  we, addr, data);
endinterface

// File: rtl/scroll_ticker.sv
// rtl/scroll_ticker.sv - scrolling message ticker for multiplexed common-anode 7-segment banks
module scroll_ticker #(
   parameter int DIGITS   = 8,
   parameter int MSG_LEN  = 16,
   parameter int SCAN_DIV = 100000,
   parameter int STEP_DIV = 50000000,
   localparam int AW = $clog2(MSG_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               dir,
   input  logic               run,
   scroll_ticker_if.slave     load,
   output logic [DIGITS-1:0]  enable,
   output logic [6:0]         seg,
   output logic               dp,
   output logic [AW-1:0]      offset
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int DW = $clog2(DIGITS);

   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [TW-1:0] STEP_LAST = TW'(STEP_DIV - 1);
   localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);
   localparam logic [AW-1:0] OFF_LAST  = AW'(MSG_LEN - 1);
   localparam logic [AW:0]   LEN_EXT   = (AW+1)'(MSG_LEN);
   localparam logic [4:0]    BLANK     = 5'h10;

   logic [SW-1:0] scan_cnt;
   logic [TW-1:0] step_cnt;
   logic [DW-1:0] digit;
   logic [4:0]    msg [MSG_LEN];

   logic [AW:0]   idx_sum;
   logic [AW-1:0] idx;
   logic          addr_ok;

   function automatic logic [6:0] decode(input logic [4:0] ch);
      logic [6:0] s;
      s = 7'h7F;
      if (!ch[4]) begin
         case (ch[3:0])
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
         endcase
      end
      return s;
   endfunction

   // Window wraps by compare-subtract so non-power-of-two buffers index correctly.
   always_comb begin
      idx_sum = {1'b0, offset} + (AW+1)'(digit);
      idx     = (idx_sum >= LEN_EXT) ? AW'(idx_sum - LEN_EXT) : AW'(idx_sum);
      addr_ok = ({1'b0, load.addr} < LEN_EXT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         step_cnt <= '0;
         digit    <= '0;
         offset   <= '0;
         enable   <= ~(DIGITS'(1));
         seg      <= 7'h7F;
         for (int i = 0; i < MSG_LEN; i++) msg[i] <= BLANK;
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            digit    <= (digit == DIG_LAST) ? '0 : digit + DW'(1);
         end else begin
            scan_cnt <= scan_cnt + SW'(1);
         end

         // Step counter and offset hold while frozen; dir only matters on the step cycle.
         if (run) begin
            if (step_cnt == STEP_LAST) begin
               step_cnt <= '0;
               if (dir) offset <= (offset == OFF_LAST) ? '0 : offset + AW'(1);
               else     offset <= (offset == '0) ? OFF_LAST : offset - AW'(1);
            end else begin
               step_cnt <= step_cnt + TW'(1);
            end
         end

         if (load.we && addr_ok) msg[load.addr] <= load.data;

         enable <= ~(DIGITS'(1) << digit);
         seg    <= decode(msg[idx]);
      end
   end

   assign dp = 1'b1;

endmodule

// File: tb/tb_scroll_ticker.sv
// tb/tb_scroll_ticker.sv - randomized self-checking bench for scroll_ticker
module tb_scroll_ticker;
   localparam int DIGITS   = 4;
   localparam int MSG_LEN  = 6;
   localparam int SCAN_DIV = 2;
   localparam int STEP_DIV = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       dir;
   logic       run;
   logic [3:0] enable;
   logic [6:0] seg;
   logic       dp;
   logic [2:0] offset;

   scroll_ticker_if #(.MSG_LEN(MSG_LEN)) lif ();

   scroll_ticker #(
      .DIGITS(DIGITS), .MSG_LEN(MSG_LEN), .SCAN_DIV(SCAN_DIV), .STEP_DIV(STEP_DIV)
   ) dut (
      .clk(clk), .rst(rst), .dir(dir), .run(run), .load(lif),
      .enable(enable), .seg(seg), .dp(dp), .offset(offset)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   // Reference state: elapsed cycles and running cycles since reset, window start, buffer.
   int         m_cyc;
   int         m_run_cyc;
   int         m_off;
   logic [4:0] m_msg [MSG_LEN];
   logic [3:0] exp_en;
   logic [6:0] exp_seg;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] char_seg(input logic [4:0] ch);
      logic [3:0] h;
      h = ch[3:0];
      return ch[4] ? 7'h7F : seg_tab[h];
   endfunction

   task automatic cycle(input logic r, input logic ru, input logic d,
                        input logic we, input logic [2:0] a, input logic [4:0] dat);
      int dg;
      rst = r; run = ru; dir = d;
      lif.we = we; lif.addr = a; lif.data = dat;
      @(posedge clk);
      if (r) begin
         m_cyc = 0; m_run_cyc = 0; m_off = 0;
         for (int i = 0; i < MSG_LEN; i++) m_msg[i] = 5'h10;
         exp_en  = 4'hE;
         exp_seg = 7'h7F;
      end else begin
         dg      = (m_cyc / SCAN_DIV) % DIGITS;
         exp_en  = ~(4'(1) << dg);
         exp_seg = char_seg(m_msg[(m_off + dg) % MSG_LEN]);
         m_cyc++;
         if (ru) begin
            m_run_cyc++;
            if (m_run_cyc % STEP_DIV == 0)
               m_off = d ? (m_off + 1) % MSG_LEN : (m_off + MSG_LEN - 1) % MSG_LEN;
         end
         if (we && int'(a) < MSG_LEN) m_msg[a] = dat;
      end
      #1;
      chk("enable", 32'(enable), 32'(exp_en));
      chk("seg",    32'(seg),    32'(exp_seg));
      chk("offset", 32'(offset), 32'(m_off));
      chk("dp",     32'(dp),     32'd1);
   endtask

   initial begin
      logic d_r;
      rst = 1'b1; run = 1'b0; dir = 1'b1;
      lif.we = 1'b0; lif.addr = '0; lif.data = '0;

      cycle(1, 0, 1, 0, 0, 0);
      chk("reset_enable", 32'(enable), 32'hE);
      chk("reset_seg",    32'(seg),    32'h7F);

      for (int i = 0; i < 20; i++) cycle(0, 0, 1, 0, 0, 0);

      for (int i = 0; i < MSG_LEN; i++) cycle(0, 0, 1, 1, 3'(i), 5'(i + 1));
      cycle(0, 0, 1, 1, 3'd6, 5'h08);
      cycle(0, 0, 1, 1, 3'd7, 5'h08);
      for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 0, 0);

      for (int i = 0; i < 70; i++) cycle(0, 1, 1, 0, 0, 0);
      chk("left_70_offset", 32'(offset), 32'd1);

      for (int i = 0; i < 15; i++) cycle(0, 1, (i < 5), 0, 0, 0);
      for (int i = 0; i < 4; i++)  cycle(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++)  cycle(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0, 0, 0);

      d_r = 1'b1;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0) d_r = ~d_r;
         cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), d_r,
               ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      end

      for (int i = 0; i < 40; i++) cycle(0, 1, 1, 0, 0, 0);
      cycle(1, 1, 1, 1, 3'd2, 5'h05);
      chk("rst_wr_offset", 32'(offset), 32'd0);
      chk("rst_wr_enable", 32'(enable), 32'hE);
      for (int i = 0; i < 12; i++) cycle(0, 0, 1, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
